spi_master_fifo: RTL and testbench
==================================

// Module: spi_master_fifo
// PURPOSE
//  Memory-mapped SPI master with TX/RX FIFOs, all four SPI modes, selectable bit order,
//  parametrised word width and multiple active-low chip selects. Sits on the CPU
//  peripheral bus (wen/addr/wdata/rdata) and lets firmware queue bursts of words
//  without polling per byte. An irq output flags received data and errors.
// PARAMETERS
//  DATA_W     8   bits per SPI word (4..32)
//  FIFO_DEPTH 4   entries in each of the TX and RX FIFOs (power of 2, >=2)
//  NUM_CS     1   number of chip-select outputs (1..8)
//  DIV_W      16  width of the clock-divider register
// PORTS
//  clk    in   1       system clock, all logic on posedge
//  reset  in   1       asynchronous, active-high reset
//  wen    in   1       bus write strobe; when low, the cycle is a read of addr
//  addr   in   32      register address; only addr[7:0] decoded
//  wdata  in   32      bus write data
//  miso   in   1       SPI serial data in
//  rdata  out  32      registered bus read data
//  sck    out  1       SPI clock
//  cs     out  NUM_CS  chip selects, active low, firmware-controlled
//  mosi   out  1       SPI serial data out
//  irq    out  1       rx_not_empty | tx_ovf | rx_ovf
// BEHAVIOUR
//  Reset values: rdata=0, sck=0, cs=all 1, mosi=1, irq=0, CLKDIV=1, MODE=0, FIFOs empty,
//   sticky flags clear, engine IDLE. Reset mid-transfer aborts the word with no RX push.
//  Registers (addr[7:0]); rdata updates 1 clk after addr while wen=0; unmapped addr reads 0:
//   0x00 TX     W: push wdata[DATA_W-1:0] into TX FIFO; if full, drop and set tx_ovf. R: 0.
//   0x04 CLKDIV RW: half-period of sck = CLKDIV+1 clk; a write also reloads the divide counter.
//   0x08 RX     R: RX FIFO head, zero-extended (0 if empty). W: any data pops (no-op if empty).
//   0x0C STATUS R: {27'b0, rx_ovf, tx_ovf, rx_not_empty, tx_full, busy}.
//               W: a 1 in bit3/bit4 clears tx_ovf/rx_ovf.
//   0x10 CS     RW: cs <= wdata[NUM_CS-1:0]; never changed by the engine.
//   0x14 MODE   RW: bit0 CPHA, bit1 CPOL, bit2 LSB_FIRST. Writes are ignored while busy.
//  busy = (state != IDLE) | TX FIFO not empty.
//  Divider: counter decrements every clk; on reaching 0 it reloads CLKDIV and emits one tick.
//   The counter runs only in SHIFT and is reloaded on entry to SHIFT.
//  FSM:
//   IDLE : sck=CPOL, mosi=1. If TX FIFO not empty -> LOAD.
//   LOAD : (1 clk) pop TX head into the shift reg; present the first bit on mosi
//          (MSB, or LSB if LSB_FIRST); edge count = 0 -> SHIFT.
//   SHIFT: on each tick toggle sck and increment edge count. Leading edges are odd, trailing even.
//          CPHA=0: sample miso on leading edges, shift the next bit out on trailing edges.
//          CPHA=1: shift out on leading edges (the first leading edge presents the first bit),
//                  sample on trailing edges.
//          After edge 2*DATA_W, sck is back at CPOL: push the RX word.
//          If the RX FIFO is full, drop the word and set rx_ovf.
//          Then -> LOAD if TX not empty, else IDLE. The inter-word gap is exactly 1 clk (LOAD).
//  Shift-in fills a vacated bit with 1 for mosi. Received word bit order follows LSB_FIRST.
//  FIFO simultaneity: bus push and engine pop in the same clk are both honoured.
//   Engine push and bus pop in the same clk are both honoured.
//   A push to a full FIFO is dropped even if a pop occurs in that clk.
//  Counts wrap using log2(FIFO_DEPTH)+1-bit pointers; full/empty come from the pointer MSB compare.
//  A CPOL change takes effect on sck in the next IDLE clk.
// TESTING
//  1 mode0, CLKDIV=0, miso tied to mosi, write TX=0xA5 -> exactly 8 rising sck edges;
//    busy low by clk 19; RX read=0xA5; irq=1 until the RX pop.
//  2 MODE=3 (CPOL=1,CPHA=1), miso driven 0x3C MSB-first -> sck idles 1; RX=0x3C; sck returns to 1.
//  3 LSB_FIRST=1, TX=0x01, mode0 -> mosi=1 on the first bit, then 0s; no glitch before the first edge.
//  4 push 6 words with FIFO_DEPTH=4 while the engine is stalled by CLKDIV=0xFFFF
//    -> tx_full=1, tx_ovf=1, 5 words transmitted back-to-back with 1-clk gaps.
//  5 send 5 words without an RX pop -> rx_ovf=1, RX holds the first 4; a STATUS write of 0x10 clears rx_ovf.
//  6 assert reset mid-word (edge 5) -> sck=0, cs=all 1, mosi=1, FIFOs empty,
//    no RX push; a new TX after reset works normally.

Source files
------------

// File: rtl/spi_master_fifo.sv
// Memory-mapped SPI master with TX/RX FIFOs, four SPI modes, selectable bit order
// and firmware-driven chip selects. irq flags received data and overflow errors.
module spi_master_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CS     = 1,
    parameter int DIV_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wen,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              miso,
    output logic [31:0]       rdata,
    output logic              sck,
    output logic [NUM_CS-1:0] cs,
    output logic              mosi,
    output logic              irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        first_bit = lsb ? w[0] : w[DATA_W-1];
    endfunction

    state_t              state_r;
    logic                sck_r;
    logic                mosi_r;
    logic                irq_r;
    logic [31:0]         rdata_r;
    logic [NUM_CS-1:0]   cs_r;
    logic [DIV_W-1:0]    clkdiv_r;
    logic [DIV_W-1:0]    div_cnt_r;
    logic [2:0]          mode_r;
    logic [EW-1:0]       edge_cnt_r;
    logic [DATA_W-1:0]   tx_sh_r;
    logic [DATA_W-1:0]   rx_sh_r;
    logic                tx_ovf_r;
    logic                rx_ovf_r;

    logic [DATA_W-1:0]   tx_mem_r [FIFO_DEPTH];
    logic [DATA_W-1:0]   rx_mem_r [FIFO_DEPTH];
    logic [PW-1:0]       tx_wr_ptr_r, tx_rd_ptr_r;
    logic [PW-1:0]       rx_wr_ptr_r, rx_rd_ptr_r;

    logic                tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic                wr_tx_s, wr_clkdiv_s, wr_rx_s, wr_status_s, wr_cs_s, wr_mode_s;
    logic                tx_push_s, tx_pop_s, rx_push_req_s, rx_push_s, rx_pop_s;
    logic                busy_s, cpha_s, cpol_s, lsb_s;
    logic                tick_s, leading_s, last_edge_s, shift_out_s, sample_s;
    logic [EW-1:0]       edge_next_s;
    logic [DATA_W-1:0]   tx_next_s, rx_next_s, rx_word_s, tx_head_s, rx_head_s;
    logic [31:0]         rd_s;
    logic                unused_s;

    assign unused_s = ^{addr, wdata};

    assign tx_empty_s = (tx_wr_ptr_r == tx_rd_ptr_r);
    assign tx_full_s  = (tx_wr_ptr_r[AW] != tx_rd_ptr_r[AW]) &&
                        (tx_wr_ptr_r[AW-1:0] == tx_rd_ptr_r[AW-1:0]);
    assign rx_empty_s = (rx_wr_ptr_r == rx_rd_ptr_r);
    assign rx_full_s  = (rx_wr_ptr_r[AW] != rx_rd_ptr_r[AW]) &&
                        (rx_wr_ptr_r[AW-1:0] == rx_rd_ptr_r[AW-1:0]);
    assign tx_head_s  = tx_mem_r[tx_rd_ptr_r[AW-1:0]];
    assign rx_head_s  = rx_mem_r[rx_rd_ptr_r[AW-1:0]];

    assign wr_tx_s     = wen && (addr[7:0] == 8'h00);
    assign wr_clkdiv_s = wen && (addr[7:0] == 8'h04);
    assign wr_rx_s     = wen && (addr[7:0] == 8'h08);
    assign wr_status_s = wen && (addr[7:0] == 8'h0C);
    assign wr_cs_s     = wen && (addr[7:0] == 8'h10);
    assign wr_mode_s   = wen && (addr[7:0] == 8'h14);

    assign busy_s = (state_r != ST_IDLE) || !tx_empty_s;
    assign cpha_s = mode_r[0];
    assign cpol_s = mode_r[1];
    assign lsb_s  = mode_r[2];

    // Engine pops in LOAD; pushes into a full FIFO are dropped regardless of a same-clk pop.
    assign tx_push_s     = wr_tx_s && !tx_full_s;
    assign tx_pop_s      = (state_r == ST_LOAD);
    assign rx_pop_s      = wr_rx_s && !rx_empty_s;
    assign rx_push_req_s = tick_s && last_edge_s;
    assign rx_push_s     = rx_push_req_s && !rx_full_s;

    assign tick_s      = (state_r == ST_SHIFT) && (div_cnt_r == {DIV_W{1'b0}});
    assign edge_next_s = edge_cnt_r + EW'(1);
    assign leading_s   = edge_next_s[0];
    assign last_edge_s = (edge_next_s == LAST_EDGE);
    // CPHA=1 keeps the bit presented in LOAD through the first leading edge.
    assign shift_out_s = tick_s && (cpha_s ? (leading_s && (edge_next_s != EW'(1))) : !leading_s);
    assign sample_s    = tick_s && (cpha_s ? !leading_s : leading_s);

    assign tx_next_s = lsb_s ? {1'b1, tx_sh_r[DATA_W-1:1]} : {tx_sh_r[DATA_W-2:0], 1'b1};
    assign rx_next_s = lsb_s ? {miso, rx_sh_r[DATA_W-1:1]} : {rx_sh_r[DATA_W-2:0], miso};
    assign rx_word_s = sample_s ? rx_next_s : rx_sh_r;

    // Bus read multiplexer; unmapped and write-only addresses return zero.
    always_comb begin
        rd_s = 32'd0;
        case (addr[7:0])
            8'h04: rd_s[DIV_W-1:0] = clkdiv_r;
            8'h08: begin
                if (!rx_empty_s) begin
                    rd_s[DATA_W-1:0] = rx_head_s;
                end else begin
                    rd_s = 32'd0;
                end
            end
            8'h0C: rd_s[4:0] = {rx_ovf_r, tx_ovf_r, !rx_empty_s, tx_full_s, busy_s};
            8'h10: rd_s[NUM_CS-1:0] = cs_r;
            8'h14: rd_s[2:0] = mode_r;
            default: rd_s = 32'd0;
        endcase
    end

    // FIFO storage, written without reset.
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_r[tx_wr_ptr_r[AW-1:0]] <= wdata[DATA_W-1:0];
        end
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r[AW-1:0]] <= rx_word_s;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr_r <= {PW{1'b0}};
            tx_rd_ptr_r <= {PW{1'b0}};
            rx_wr_ptr_r <= {PW{1'b0}};
            rx_rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PW'(1);
            if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + PW'(1);
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PW'(1);
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PW'(1);
        end
    end

    // Configuration registers and sticky error flags; a set wins over a same-clk clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkdiv_r <= DIV_W'(1);
            mode_r   <= 3'd0;
            cs_r     <= {NUM_CS{1'b1}};
            tx_ovf_r <= 1'b0;
            rx_ovf_r <= 1'b0;
        end else begin
            if (wr_clkdiv_s) clkdiv_r <= wdata[DIV_W-1:0];
            if (wr_mode_s && !busy_s) mode_r <= wdata[2:0];
            if (wr_cs_s) cs_r <= wdata[NUM_CS-1:0];
            if (wr_tx_s && tx_full_s) begin
                tx_ovf_r <= 1'b1;
            end else if (wr_status_s && wdata[3]) begin
                tx_ovf_r <= 1'b0;
            end
            if (rx_push_req_s && rx_full_s) begin
                rx_ovf_r <= 1'b1;
            end else if (wr_status_s && wdata[4]) begin
                rx_ovf_r <= 1'b0;
            end
        end
    end

    // Shift engine FSM with divider, sck and mosi.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            sck_r      <= 1'b0;
            mosi_r     <= 1'b1;
            edge_cnt_r <= {EW{1'b0}};
            div_cnt_r  <= {DIV_W{1'b0}};
            tx_sh_r    <= {DATA_W{1'b1}};
            rx_sh_r    <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sck_r  <= cpol_s;
                    mosi_r <= 1'b1;
                    state_r <= tx_empty_s ? ST_IDLE : ST_LOAD;
                end
                ST_LOAD: begin
                    tx_sh_r    <= tx_head_s;
                    mosi_r     <= first_bit(tx_head_s, lsb_s);
                    rx_sh_r    <= {DATA_W{1'b0}};
                    edge_cnt_r <= {EW{1'b0}};
                    div_cnt_r  <= clkdiv_r;
                    state_r    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tick_s) begin
                        div_cnt_r  <= clkdiv_r;
                        sck_r      <= ~sck_r;
                        edge_cnt_r <= edge_next_s;
                        if (shift_out_s) begin
                            tx_sh_r <= tx_next_s;
                            mosi_r  <= first_bit(tx_next_s, lsb_s);
                        end
                        if (sample_s) begin
                            rx_sh_r <= rx_next_s;
                        end
                        if (last_edge_s) begin
                            state_r <= tx_empty_s ? ST_IDLE : ST_LOAD;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r - DIV_W'(1);
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
            if (wr_clkdiv_s) begin
                div_cnt_r <= wdata[DIV_W-1:0];
            end
        end
    end

    // Registered bus read data and interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r <= 32'd0;
            irq_r   <= 1'b0;
        end else begin
            if (!wen) rdata_r <= rd_s;
            irq_r <= !rx_empty_s || tx_ovf_r || rx_ovf_r;
        end
    end

    assign rdata = rdata_r;
    assign sck   = sck_r;
    assign cs    = cs_r;
    assign mosi  = mosi_r;
    assign irq   = irq_r;

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: register vector table plus transfer sequences
// (loopback, mode 3 slave, LSB-first, FIFO overflow, reset mid-word).
module tb_spi_master_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wen = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        miso;
    logic [31:0] rdata;
    logic        sck;
    logic [0:0]  cs;
    logic        mosi;
    logic        irq;

    logic        loop_en = 1'b1;
    logic        slave_en = 1'b0;
    logic        slave_bit = 1'b0;
    logic [7:0]  slave_word = 8'h00;
    int          slave_idx = 0;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rise_cnt = 0;
    int          mosi_chg = 0;
    int          rise_q[$];
    logic [7:0]  mosi_cap = 8'h00;

    assign miso = loop_en ? mosi : slave_bit;

    spi_master_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .NUM_CS(1), .DIV_W(16)) dut (
        .clk(clk), .reset(reset), .wen(wen), .addr(addr), .wdata(wdata), .miso(miso),
        .rdata(rdata), .sck(sck), .cs(cs), .mosi(mosi), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) cyc <= cyc + 1;

    always @(posedge sck) begin
        rise_cnt <= rise_cnt + 1;
        rise_q.push_back(cyc);
        mosi_cap <= {mosi_cap[6:0], mosi};
    end

    always @(mosi) mosi_chg = mosi_chg + 1;

    // Mode-3 slave: present the next MSB-first bit on each leading (falling) edge.
    always @(sck) begin
        if (slave_en && (sck == 1'b0) && (slave_idx < 8)) begin
            slave_bit = slave_word[7 - slave_idx];
            slave_idx = slave_idx + 1;
        end
    end

    typedef struct packed {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus tasks start and end at a negedge of clk.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wen = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        wen = 1'b0; addr = a;
        @(negedge clk);
        d = rdata;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        logic [31:0] st;
        st = 32'h1;
        for (int i = 0; i < budget; i++) begin
            bus_read(32'h0C, st);
            if (st[0] == 1'b0) break;
        end
        check(name, {31'd0, st[0]}, 32'd0);
    endtask

    task automatic wait_rises(input int n, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (rise_cnt >= n) break;
            @(negedge clk);
        end
        check(name, {31'd0, rise_cnt >= n}, 32'd1);
    endtask

    task automatic clear_capture();
        rise_cnt = 0;
        rise_q.delete();
        mosi_chg = 0;
    endtask

    initial begin
        logic [31:0] d;
        int chg_snap;

        vecs[0]  = '{1'b0, 32'h04,  32'h1};
        vecs[1]  = '{1'b0, 32'h14,  32'h0};
        vecs[2]  = '{1'b0, 32'h10,  32'h1};
        vecs[3]  = '{1'b0, 32'h0C,  32'h0};
        vecs[4]  = '{1'b0, 32'h08,  32'h0};
        vecs[5]  = '{1'b0, 32'h00,  32'h0};
        vecs[6]  = '{1'b1, 32'h04,  32'hABCD5678};
        vecs[7]  = '{1'b0, 32'h04,  32'h5678};
        vecs[8]  = '{1'b0, 32'h104, 32'h5678};
        vecs[9]  = '{1'b0, 32'h3C,  32'h0};
        vecs[10] = '{1'b1, 32'h14,  32'hFFFFFFFF};
        vecs[11] = '{1'b0, 32'h14,  32'h7};
        vecs[12] = '{1'b1, 32'h10,  32'h0};
        vecs[13] = '{1'b0, 32'h10,  32'h0};
        vecs[14] = '{1'b1, 32'h10,  32'h1};
        vecs[15] = '{1'b1, 32'h14,  32'h0};
        vecs[16] = '{1'b1, 32'h04,  32'h0};
        vecs[17] = '{1'b0, 32'h04,  32'h0};

        ticks(2);
        #1;
        check("rst_sck", {31'd0, sck}, 32'd0);
        check("rst_cs", {31'd0, cs}, 32'd1);
        check("rst_mosi", {31'd0, mosi}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].a, vecs[i].d);
            end else begin
                bus_read(vecs[i].a, d);
                check($sformatf("reg_vec[%0d]", i), d, vecs[i].d);
            end
        end
        ticks(2);

        // Mode 0 loopback of 0xA5.
        loop_en = 1'b1;
        clear_capture();
        bus_write(32'h00, 32'hA5);
        wait_idle(60, "t1_idle");
        check("t1_rises", rise_cnt, 32'd8);
        check("t1_irq_set", {31'd0, irq}, 32'd1);
        read_check("t1_status", 32'h0C, 32'h04);
        read_check("t1_rx", 32'h08, 32'hA5);
        bus_write(32'h08, 32'h0);
        ticks(2);
        check("t1_irq_clr", {31'd0, irq}, 32'd0);

        // Mode 3 with a slave driving 0x3C.
        bus_write(32'h14, 32'h3);
        ticks(2);
        check("t2_idle_cpol", {31'd0, sck}, 32'd1);
        loop_en = 1'b0;
        slave_word = 8'h3C;
        slave_idx = 0;
        slave_en = 1'b1;
        clear_capture();
        bus_write(32'h00, 32'h96);
        wait_idle(60, "t2_idle");
        check("t2_rises", rise_cnt, 32'd8);
        check("t2_sck_end", {31'd0, sck}, 32'd1);
        read_check("t2_rx", 32'h08, 32'h3C);
        bus_write(32'h08, 32'h0);
        slave_en = 1'b0;
        bus_write(32'h14, 32'h0);
        ticks(2);
        check("t2_cpol_back", {31'd0, sck}, 32'd0);

        // LSB-first 0x01 in mode 0.
        bus_write(32'h14, 32'h4);
        loop_en = 1'b1;
        ticks(1);
        clear_capture();
        bus_write(32'h00, 32'h01);
        wait_rises(1, 20, "t3_first_edge");
        chg_snap = mosi_chg;
        check("t3_no_glitch", chg_snap, 32'd0);
        wait_idle(60, "t3_idle");
        check("t3_mosi_bits", {24'd0, mosi_cap}, 32'h80);
        read_check("t3_rx", 32'h08, 32'h01);
        bus_write(32'h08, 32'h0);

        // Six pushes against a stalled engine, then release the divider.
        bus_write(32'h14, 32'h0);
        bus_write(32'h04, 32'hFFFF);
        clear_capture();
        for (int i = 1; i <= 6; i++) bus_write(32'h00, 32'h11 * i);
        read_check("t4_status_full", 32'h0C, 32'h0B);
        bus_write(32'h04, 32'h0);
        wait_idle(300, "t4_idle");
        check("t4_rises", rise_cnt, 32'd40);
        if (rise_q.size() >= 40) begin
            check("t4_bit_gap", rise_q[1] - rise_q[0], 32'd2);
            for (int k = 1; k <= 4; k++)
                check($sformatf("t4_word_gap[%0d]", k), rise_q[8*k] - rise_q[8*k-1], 32'd3);
        end else begin
            check("t4_rise_log", rise_q.size(), 32'd40);
        end
        read_check("t4_status_ovf", 32'h0C, 32'h1C);
        for (int i = 1; i <= 4; i++) begin
            read_check($sformatf("t5_rx[%0d]", i), 32'h08, 32'h11 * i);
            bus_write(32'h08, 32'h0);
        end
        read_check("t5_rx_empty", 32'h08, 32'h0);
        read_check("t5_status_pop", 32'h0C, 32'h18);
        bus_write(32'h0C, 32'h10);
        read_check("t5_rxovf_clr", 32'h0C, 32'h08);
        bus_write(32'h0C, 32'h08);
        read_check("t5_txovf_clr", 32'h0C, 32'h00);
        ticks(2);
        check("t5_irq_clr", {31'd0, irq}, 32'd0);

        // Reset in the middle of a word.
        bus_write(32'h10, 32'h0);
        ticks(1);
        check("t6_cs_low", {31'd0, cs}, 32'd0);
        bus_write(32'h04, 32'h3);
        clear_capture();
        bus_write(32'h00, 32'h5A);
        wait_rises(3, 100, "t6_edge5");
        reset = 1'b1;
        #1;
        check("t6_sck", {31'd0, sck}, 32'd0);
        check("t6_cs", {31'd0, cs}, 32'd1);
        check("t6_mosi", {31'd0, mosi}, 32'd1);
        check("t6_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        read_check("t6_status", 32'h0C, 32'h0);
        read_check("t6_rx", 32'h08, 32'h0);
        read_check("t6_clkdiv", 32'h04, 32'h1);
        clear_capture();
        bus_write(32'h00, 32'hC3);
        wait_idle(120, "t6_idle");
        check("t6_rises", rise_cnt, 32'd8);
        read_check("t6_rx_new", 32'h08, 32'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
